// File: rtl/async_fifo_core.sv
// async_fifo_core: single-clock FIFO with a registered read port.
// Buffers words from a bursty producer for a slower consumer.
// It reports full/empty and almost_full/almost_empty status so both sides
// can throttle themselves.
//
// Optional feature macro: ASYNC_FIFO_ERR_FLAGS_EN
//   When defined, the module adds the sticky outputs overflow and underflow.
//   Only rst_n clears them.
//   When undefined, those ports and their logic are not present.
//
// Handshake semantics:
//   Write side: a word is taken at a rising clk edge when wr_en=1 and full=0,
//   with full taken as it was just before that edge. Writes requested while
//   full are dropped and change no state.
//   Read side: a word is taken at a rising clk edge when rd_en=1 and empty=0,
//   with empty taken as it was just before that edge. The word appears on
//   rd_data after that edge.
//   A read requested while empty drives rd_data to 0 and leaves the pointers
//   unchanged. While rd_en is low, rd_data holds its value.
//   There is no write-to-read bypass, so a read and a write at empty only
//   store the word.
//
// FIFO_DEPTH must equal 2**ADDR_WIDTH.

module async_fifo_core #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 6,
  parameter int FIFO_DEPTH    = 64,
  parameter int ALMOST_MARGIN = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int PW = ADDR_WIDTH + 1;

  // Thresholds are held at pointer width so every compare is width-matched.
  localparam logic [PW-1:0] LP_ONE       = PW'(1);
  localparam logic [PW-1:0] LP_DEPTH     = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LP_AF_LEVEL  = PW'(FIFO_DEPTH - ALMOST_MARGIN);
  localparam logic [PW-1:0] LP_AE_LEVEL  = PW'(ALMOST_MARGIN);

  // Storage array. It has no reset, so its contents survive rst_n.
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

  // Pointers carry one extra wrap bit above the memory index.
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic [PW-1:0]         w_count;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_accept;
  logic                  w_rd_accept;

  assign w_wr_addr = r_wr_ptr[ADDR_WIDTH-1:0];
  assign w_rd_addr = r_rd_ptr[ADDR_WIDTH-1:0];

  // Occupancy comes from modulo subtraction of the pointers.
  // The wrap bit tells full apart from empty.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_count == LP_DEPTH);
  assign w_empty = (w_count == '0);

  // Each side is qualified on the flags decoded from the registered pointers.
  assign w_wr_accept = wr_en && !w_full;
  assign w_rd_accept = rd_en && !w_empty;

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (w_count >= LP_AF_LEVEL);
  assign almost_empty = (w_count <= LP_AE_LEVEL);
  assign rd_data      = r_rd_data;

  // Store accepted words. This is gated by rst_n so that a wr_en held during
  // reset never touches the array.
  always_ff @(posedge clk) begin
    if (rst_n && w_wr_accept) begin
      r_mem[w_wr_addr] <= wr_data;
    end
  end

  // Advance the write pointer on every accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
    end else if (w_wr_accept) begin
      r_wr_ptr <= r_wr_ptr + LP_ONE;
    end
  end

  // Advance the read pointer on every accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
    end else if (w_rd_accept) begin
      r_rd_ptr <= r_rd_ptr + LP_ONE;
    end
  end

  // Registered read port: load the head word, load 0 on an empty read, or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      r_rd_data <= w_empty ? '0 : r_mem[w_rd_addr];
    end
  end

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error flags. They record any refused request until the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && w_full) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_async_fifo_core.sv
// Testbench for async_fifo_core (default parameters: 8-bit data, 64 entries, margin 4).
// It compares the design against a queue-based reference model and a table
// of hand-computed vectors.
module tb_async_fifo_core;

  localparam int DW     = 8;
  localparam int DEPTH  = 64;
  localparam int MARGIN = 4;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          full, empty, almost_full, almost_empty;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  logic          overflow, underflow;
`endif

  always #5 clk = ~clk;

  async_fifo_core #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(6), .FIFO_DEPTH(DEPTH), .ALMOST_MARGIN(MARGIN)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty)
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  // ---------------- scoreboard / reference model ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_rd;
  logic          exp_ovf, exp_unf;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_rd  = '0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
  endtask

  // One clock edge of the model: flags are judged on the occupancy before the edge.
  task automatic model_edge(input logic w, input logic [DW-1:0] d, input logic r);
    int n_before;
    n_before = exp_q.size();
    if (r) begin
      if (n_before != 0) exp_rd = exp_q.pop_front();
      else begin
        exp_rd = '0;
        exp_unf = 1'b1;
      end
    end
    if (w) begin
      if (n_before < DEPTH) exp_q.push_back(d);
      else exp_ovf = 1'b1;
    end
  endtask

  task automatic compare_all(input string tag);
    int n;
    n = exp_q.size();
    check({tag, ".rd_data"}, 32'(rd_data), 32'(exp_rd));
    check({tag, ".empty"}, 32'(empty), 32'(n == 0));
    check({tag, ".full"}, 32'(full), 32'(n == DEPTH));
    check({tag, ".almost_full"}, 32'(almost_full), 32'(n >= DEPTH - MARGIN));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= MARGIN));
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    check({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(exp_unf));
`endif
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same offset.
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input string tag);
    wr_en = w; wr_data = d; rd_en = r;
    @(posedge clk);
    model_edge(w, d, r);
    #1;
    compare_all(tag);
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    wr_en = 1'b1;          // a pending write during reset must be ignored
    wr_data = 8'hEE;
    rst_n = 1'b0;
    model_reset();
    #100;
    compare_all("reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    compare_all("post_reset");
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          w;
    logic [DW-1:0] d;
    logic          r;
    logic [DW-1:0] e_rd;
    logic          e_empty;
    logic          e_full;
    logic          e_ae;
    logic          e_af;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0}; // read on empty -> 0
    vecs[1]  = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}; // count 1
    vecs[2]  = '{1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}; // count 2
    vecs[3]  = '{1'b1, 8'h7E, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0}; // rd+wr, count 2
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0}; // count 1
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0}; // hold
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 8'h7E, 1'b1, 1'b0, 1'b1, 1'b0}; // drained
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0}; // empty read -> 0
    vecs[8]  = '{1'b1, 8'h11, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}; // rd+wr at empty: no bypass
    vecs[9]  = '{1'b1, 8'h22, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}; // count 2
    vecs[10] = '{1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}; // count 3
    vecs[11] = '{1'b1, 8'h44, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}; // count 4
    vecs[12] = '{1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}; // count 5: almost_empty drops
    vecs[13] = '{1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0}; // count 4
  end

  // ---------------- test sequence ----------------
  initial begin
    int wr_cnt;
    int rd_cnt;
    model_reset();
    #1;

    // Reset: rst_n is held low for 100 ns.
    do_reset();

    // Directed table, checked against both the table constants and the model.
    for (int i = 0; i < 14; i++) begin
      cycle(vecs[i].w, vecs[i].d, vecs[i].r, $sformatf("vec%0d", i));
      check($sformatf("vec%0d.tbl_rd", i), 32'(rd_data), 32'(vecs[i].e_rd));
      check($sformatf("vec%0d.tbl_flags", i), {28'd0, empty, full, almost_empty, almost_full},
            {28'd0, vecs[i].e_empty, vecs[i].e_full, vecs[i].e_ae, vecs[i].e_af});
    end

    // Basic: write 0..9, then read 10 words with 1-cycle latency.
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, DW'(i), 1'b0, "basic_wr");
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, '0, 1'b1, "basic_rd");
      check("basic_order", 32'(rd_data), 32'(i));
    end

    // Full: store 0..63, drop 0xFF, then read back 0..63.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, DW'(i), 1'b0, "fill");
      if (i == DEPTH - MARGIN - 1) check("af_at_60", 32'(almost_full), 32'd1);
      if (i == DEPTH - MARGIN - 2) check("af_at_59", 32'(almost_full), 32'd0);
    end
    check("full_after_64", 32'(full), 32'd1);
    cycle(1'b1, 8'hFF, 1'b0, "drop_ff");
    check("still_full", 32'(full), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, '0, 1'b1, "drain");
      check("drain_order", 32'(rd_data), 32'(i));
      if (DEPTH - 1 - i == MARGIN) check("ae_at_4", 32'(almost_empty), 32'd1);
      if (DEPTH - 1 - i == MARGIN + 1) check("ae_at_5", 32'(almost_empty), 32'd0);
    end
    check("empty_after_drain", 32'(empty), 32'd1);
    cycle(1'b0, '0, 1'b1, "empty_read");

    // Concurrent read/write for 20 cycles with data present.
    for (int i = 0; i < 6; i++) cycle(1'b1, DW'(8'h80 + i), 1'b0, "pre_conc");
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, DW'(8'hA0 + i), 1'b1, "conc");
      check("conc_count", 32'(exp_q.size()), 32'd6);
    end

    // Concurrent at full: only the read proceeds.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i * 3), 1'b0, "fill2");
    cycle(1'b1, 8'h5A, 1'b1, "rw_at_full");
    check("rw_full_rd", 32'(rd_data), 32'd0);

    // Mid-write reset: assert rst_n asynchronously while a write is being presented.
    wr_en = 1'b1; wr_data = 8'hC3; rd_en = 1'b0;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all("mid_reset");
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    compare_all("mid_reset_rel");
    cycle(1'b0, '0, 1'b1, "no_stale");
    check("no_stale_rd", 32'(rd_data), 32'd0);
    cycle(1'b1, 8'h5C, 1'b0, "first_wr");
    cycle(1'b0, '0, 1'b1, "first_rd");
    check("first_rd_val", 32'(rd_data), 32'h5C);

    // Randomised traffic; the bias flips between phases so the run reaches both full and empty.
    do_reset();
    wr_cnt = 0; rd_cnt = 0;
    for (int ph = 0; ph < 8; ph++) begin
      for (int i = 0; i < 120; i++) begin
        logic w, r;
        w = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 80 : 25));
        r = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 25 : 80));
        cycle(w, DW'($urandom_range(0, 255)), r, $sformatf("rnd%0d", ph));
      end
    end
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
